// File: rtl/jtkcpu_busresp_if.sv
// CPU-side request/response and external byte-bus signals of jtkcpu_busresp.
// The slave modport is the bus responder; the master modport is the CPU and memory side.
interface jtkcpu_busresp_if;
    logic        req;
    logic [15:0] addr;
    logic        wrq;
    logic        wide;
    logic [15:0] dout;
    logic [15:0] mdata;
    logic        mem_busy;
    logic        buserror;
    logic [15:0] ext_addr;
    logic        ext_cs;
    logic        ext_we;
    logic [7:0]  ext_dout;
    logic [7:0]  ext_din;
    logic        ext_ok;

    modport slave (
        input  req, addr, wrq, wide, dout, ext_din, ext_ok,
        output mdata, mem_busy, buserror, ext_addr, ext_cs, ext_we, ext_dout
    );

    modport master (
        output req, addr, wrq, wide, dout, ext_din, ext_ok,
        input  mdata, mem_busy, buserror, ext_addr, ext_cs, ext_we, ext_dout
    );
endinterface

// File: rtl/jtkcpu_busresp.sv
// Splits 8/16-bit CPU accesses into big-endian byte accesses on an external bus, with wait timeout.
// One cen cycle of request latency; ext_ok stretches each byte, new requests are ignored while busy.
module jtkcpu_busresp #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    jtkcpu_busresp_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, ERR} state_t;

    state_t      state, state_nxt;
    logic [15:0] addr_r;
    logic [15:0] dout_r;
    logic        wrq_r;
    logic        wide_r;
    logic [7:0]  wait_cnt;
    logic [15:0] mdata_r;
    logic        mem_busy_r;
    logic        buserror_r;
    logic [15:0] ext_addr_r;
    logic        ext_cs_r;
    logic [7:0]  ext_dout_r;

    logic        start;
    logic        byte_ok;
    logic        byte_to;
    logic        cs_on;
    logic        last_wait;

    // The wait that would bring the counter to TIMEOUT is the last one tolerated.
    assign last_wait = (wait_cnt == TIMEOUT - 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (cen) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        byte_ok   = 1'b0;
        byte_to   = 1'b0;
        cs_on     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    start     = 1'b1;
                    state_nxt = BYTE0;
                end
            end
            BYTE0, BYTE1: begin
                if (!ext_cs_r) begin
                    // Gap cycle before the second byte; ext_ok is ignored here.
                    cs_on = 1'b1;
                end else if (bus.ext_ok) begin
                    byte_ok   = 1'b1;
                    state_nxt = (state == BYTE0 && wide_r) ? BYTE1 : IDLE;
                end else if (last_wait) begin
                    byte_to   = 1'b1;
                    state_nxt = ERR;
                end
            end
            ERR: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r     <= 16'h0000;
            dout_r     <= 16'h0000;
            wrq_r      <= 1'b0;
            wide_r     <= 1'b0;
            wait_cnt   <= 8'd0;
            mdata_r    <= 16'h0000;
            mem_busy_r <= 1'b0;
            buserror_r <= 1'b0;
            ext_addr_r <= 16'h0000;
            ext_cs_r   <= 1'b0;
            ext_dout_r <= 8'h00;
        end else if (cen) begin
            buserror_r <= byte_to;
            if (ext_cs_r && !bus.ext_ok) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (start) begin
                addr_r     <= bus.addr;
                dout_r     <= bus.dout;
                wrq_r      <= bus.wrq;
                wide_r     <= bus.wide;
                wait_cnt   <= 8'd0;
                mem_busy_r <= 1'b1;
                ext_cs_r   <= 1'b1;
                ext_addr_r <= bus.addr;
                ext_dout_r <= bus.wide ? bus.dout[15:8] : bus.dout[7:0];
            end
            if (cs_on) begin
                ext_cs_r <= 1'b1;
            end
            if (byte_ok) begin
                wait_cnt <= 8'd0;
                ext_cs_r <= 1'b0;
                if (!wrq_r) begin
                    if (state == BYTE1) begin
                        mdata_r[7:0] <= bus.ext_din;
                    end else if (wide_r) begin
                        mdata_r[15:8] <= bus.ext_din;
                    end else begin
                        mdata_r <= {8'h00, bus.ext_din};
                    end
                end
                if (state == BYTE0 && wide_r) begin
                    ext_addr_r <= addr_r + 16'd1;
                    ext_dout_r <= dout_r[7:0];
                end else begin
                    mem_busy_r <= 1'b0;
                end
            end
            if (byte_to) begin
                ext_cs_r <= 1'b0;
                if (!wrq_r) begin
                    mdata_r <= 16'h0000;
                end
            end
            if (state == ERR) begin
                mem_busy_r <= 1'b0;
            end
        end
    end

    assign bus.mdata    = mdata_r;
    assign bus.mem_busy = mem_busy_r;
    assign bus.buserror = buserror_r;
    assign bus.ext_addr = ext_addr_r;
    assign bus.ext_cs   = ext_cs_r;
    assign bus.ext_we   = ext_cs_r & wrq_r;
    assign bus.ext_dout = ext_dout_r;

endmodule

// File: tb/tb_jtkcpu_busresp.sv
// Directed checks of jtkcpu_busresp: a vector table for the basic accesses plus
// hand-written sequences for timeout, clock gating, busy requests and mid-access reset.
module tb_jtkcpu_busresp;

    logic clk = 1'b0;
    logic rst;
    logic cen;

    always #5 clk = ~clk;

    jtkcpu_busresp_if bus();

    jtkcpu_busresp #(.TIMEOUT(8'd4)) dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .bus (bus)
    );

    int n_tests   = 0;
    int n_fail    = 0;
    int berr_seen = 0;

    typedef struct {
        logic        cen, req, wrq, wide, ok;
        logic [15:0] addr, dout;
        logic [7:0]  din;
        logic        busy, cs, we, berr;
        logic [15:0] eaddr;
        logic [7:0]  edout;
        logic [15:0] mdata;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.buserror === 1'b1) berr_seen++;
    endtask

    task automatic drive(input logic c, input logic r, input logic w, input logic wd,
                         input logic ok, input logic [15:0] a, input logic [15:0] d,
                         input logic [7:0] din);
        cen         = c;
        bus.req     = r;
        bus.wrq     = w;
        bus.wide    = wd;
        bus.ext_ok  = ok;
        bus.addr    = a;
        bus.dout    = d;
        bus.ext_din = din;
    endtask

    task automatic check_out(input string tag, input logic busy, input logic cs,
                             input logic we, input logic berr, input logic [15:0] ea,
                             input logic [7:0] ed, input logic [15:0] md);
        check({tag, " mem_busy"}, {15'd0, bus.mem_busy}, {15'd0, busy});
        check({tag, " ext_cs"},   {15'd0, bus.ext_cs},   {15'd0, cs});
        check({tag, " ext_we"},   {15'd0, bus.ext_we},   {15'd0, we});
        check({tag, " buserror"}, {15'd0, bus.buserror}, {15'd0, berr});
        check({tag, " ext_addr"}, bus.ext_addr, ea);
        check({tag, " ext_dout"}, {8'd0, bus.ext_dout}, {8'd0, ed});
        check({tag, " mdata"},    bus.mdata, md);
    endtask

    // Wide read of bytes 11,22 with req held throughout; cen active every 'stretch' edges.
    task automatic run_wide(input int stretch, input logic [15:0] a, input logic [15:0] prev);
        int          k;
        logic [15:0] a1;
        logic [15:0] mid;
        string       tag;
        a1  = a + 16'd1;
        mid = {8'h11, prev[7:0]};
        for (int e = 0; e < 4 * stretch; e++) begin
            k = e / stretch;
            drive((e % stretch) == 0, 1'b1, 1'b0, 1'b1, 1'b1, a, 16'h0000,
                  (k == 3) ? 8'h22 : 8'h11);
            step();
            k   = e / stretch + 1;
            tag = $sformatf("wide x%0d edge%0d", stretch, e);
            case (k)
                1:       check_out(tag, 1'b1, 1'b1, 1'b0, 1'b0, a,  8'h00, prev);
                2:       check_out(tag, 1'b1, 1'b0, 1'b0, 1'b0, a1, 8'h00, mid);
                3:       check_out(tag, 1'b1, 1'b1, 1'b0, 1'b0, a1, 8'h00, mid);
                default: check_out(tag, 1'b0, 1'b0, 1'b0, 1'b0, a1, 8'h00, 16'h1122);
            endcase
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, a, 16'h0000, 8'h00);
        step();
        check($sformatf("wide x%0d single access busy", stretch), {15'd0, bus.mem_busy}, 16'd0);
        check($sformatf("wide x%0d single access cs", stretch),   {15'd0, bus.ext_cs},   16'd0);
    endtask

    initial begin
        int berr_base;

        //         cen req wrq wide ok  addr      dout      din     busy cs we berr eaddr    edout  mdata
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 8'h00, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 8'h00, 16'h0000};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 8'h00, 16'h0000};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 16'h005A};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 8'h00, 16'h005A};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h125A};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h125A};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h1234};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0100, 16'hABCD, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0100, 8'hAB, 16'h1234};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0100, 16'hABCD, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0100, 8'hAB, 16'h1234};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0100, 16'hABCD, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0101, 8'hCD, 16'h1234};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0100, 16'hABCD, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0101, 8'hCD, 16'h1234};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0100, 16'hABCD, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0101, 8'hCD, 16'h1234};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h2000, 16'h0077, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h2000, 8'h77, 16'h1234};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h2222, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2000, 8'h77, 16'h1234};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2000, 8'h77, 16'h1234};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2000, 8'h77, 16'h1234};

        // Reset must act even with cen low.
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hBEEF, 16'hCAFE, 8'h77);
        step();
        check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h0000);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00);
        step();
        check_out("idle after reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h0000);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].cen, vecs[i].req, vecs[i].wrq, vecs[i].wide, vecs[i].ok,
                  vecs[i].addr, vecs[i].dout, vecs[i].din);
            step();
            check_out($sformatf("vec%0d", i), vecs[i].busy, vecs[i].cs, vecs[i].we,
                      vecs[i].berr, vecs[i].eaddr, vecs[i].edout, vecs[i].mdata);
        end

        // Timeout: ext_ok never comes, TIMEOUT=4.
        berr_base = berr_seen;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h4000, 16'h0000, 8'h00);
        step();
        bus.req = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check_out($sformatf("timeout wait%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 16'h4000, 8'h00, 16'h1234);
        end
        step();
        check_out("timeout err", 1'b1, 1'b0, 1'b0, 1'b1, 16'h4000, 8'h00, 16'h0000);
        step();
        check_out("timeout done", 1'b0, 1'b0, 1'b0, 1'b0, 16'h4000, 8'h00, 16'h0000);
        repeat (3) step();
        check("timeout pulse count", 16'(berr_seen - berr_base), 16'd1);

        // ext_ok on the last tolerated wait cycle completes normally.
        berr_base = berr_seen;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h4001, 16'h0000, 8'h00);
        step();
        bus.req = 1'b0;
        repeat (3) step();
        bus.ext_ok  = 1'b1;
        bus.ext_din = 8'hC3;
        step();
        check_out("late ok", 1'b0, 1'b0, 1'b0, 1'b0, 16'h4001, 8'h00, 16'h00C3);
        bus.ext_ok = 1'b0;
        repeat (2) step();
        check("late ok no buserror", 16'(berr_seen - berr_base), 16'd0);

        // Req held through a wide read, first with cen always on, then cen toggling.
        run_wide(1, 16'h5000, 16'h00C3);
        run_wide(2, 16'h5000, 16'h1122);

        // Reset during the second byte of a wide read.
        berr_base = berr_seen;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h6000, 16'h0000, 8'h00);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h6000, 16'h0000, 8'hAA);
        step();
        bus.ext_ok = 1'b0;
        step();
        check("byte1 reached cs",   {15'd0, bus.ext_cs}, 16'd1);
        check("byte1 reached addr", bus.ext_addr, 16'h6001);
        rst         = 1'b1;
        bus.ext_ok  = 1'b1;
        bus.ext_din = 8'hBB;
        step();
        check_out("reset in byte1", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h0000);
        rst        = 1'b0;
        bus.ext_ok = 1'b0;
        repeat (2) step();
        check_out("after reset idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h6100, 16'h0000, 8'h00);
        step();
        check_out("post reset accept", 1'b1, 1'b1, 1'b0, 1'b0, 16'h6100, 8'h00, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h6100, 16'h0000, 8'h5C);
        step();
        check_out("post reset read", 1'b0, 1'b0, 1'b0, 1'b0, 16'h6100, 8'h00, 16'h005C);
        check("reset no buserror", 16'(berr_seen - berr_base), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
